// File: rtl/rsa_precompute_if.sv
// rsa_precompute_if: request/result bundle between a requester and the Montgomery constant precompute block.
interface rsa_precompute_if #(parameter int WIDTH = 64);
    logic             start;
    logic [WIDTH-1:0] N;
    logic [WIDTH-1:0] N_INV;
    logic [WIDTH-1:0] R2_MOD_N;
    logic             busy;
    logic             done;
    logic             err;
    modport master (output start, N, input N_INV, R2_MOD_N, busy, done, err);
    modport slave (input start, N, output N_INV, R2_MOD_N, busy, done, err);
endinterface

// File: rtl/rsa_precompute.sv
// rsa_precompute: bit-serial -N^-1 mod 2^WIDTH and 2^(2*WIDTH) mod N for a Montgomery exponentiation core.
module rsa_precompute #(
    parameter int WIDTH = 64
) (
    input logic           clk,
    input logic           rst_n,
    rsa_precompute_if.slave bus
);
    localparam int CW = $clog2(2 * WIDTH);
    localparam int BW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, INV, R2, DONE} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] n_q, x, t, n_inv, r2, x_nx, t_nx;
    logic [WIDTH:0]   r, d, r_nx;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    bi;
    logic             done_q, err_q, bad_q, accept, bad, inv_last, r2_last;
    // done may still be high in IDLE after an invalid-N completion; no start is taken then
    assign accept   = state == IDLE && bus.start && !done_q;
    assign bad      = !bus.N[0] || bus.N < WIDTH'(3);
    assign inv_last = cnt == CW'(WIDTH - 1);
    assign r2_last  = cnt == CW'(2 * WIDTH - 1);
    assign bi       = cnt[BW-1:0];
    assign x_nx     = t[bi] ? x | (WIDTH'(1) << bi) : x;
    assign t_nx     = t[bi] ? t + (n_q << bi) : t;
    assign d        = {r[WIDTH-1:0], 1'b0};
    assign r_nx     = d >= {1'b0, n_q} ? d - {1'b0, n_q} : d;
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: state_nx = accept ? (bad ? DONE : INV) : IDLE;
            INV:  state_nx = inv_last ? R2 : INV;
            R2:   state_nx = r2_last ? DONE : R2;
            DONE: state_nx = IDLE;
        endcase
    end
    always_comb begin
        bus.busy = state == INV || state == R2;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_q    <= '0;
            x      <= '0;
            t      <= '0;
            r      <= '0;
            cnt    <= '0;
            n_inv  <= '0;
            r2     <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            bad_q  <= 1'b0;
        end else begin
            done_q <= (state == R2 && r2_last) || (state == DONE && bad_q);
            unique case (state)
                IDLE: if (accept) begin
                    n_q   <= bus.N;
                    bad_q <= bad;
                    err_q <= 1'b0;
                    x     <= WIDTH'(1);
                    t     <= bus.N;
                    cnt   <= CW'(1);
                    if (bad) begin
                        n_inv <= '0;
                        r2    <= '0;
                    end
                end
                // t tracks n_q*x; clearing bit cnt of t builds x = n_q^-1 one bit per cycle
                INV: begin
                    x   <= x_nx;
                    t   <= t_nx;
                    cnt <= inv_last ? '0 : cnt + 1'b1;
                    if (inv_last) begin
                        n_inv <= ~x_nx + 1'b1;
                        r     <= (WIDTH + 1)'(1);
                    end
                end
                R2: begin
                    r   <= r_nx;
                    cnt <= cnt + 1'b1;
                    if (r2_last) r2 <= r_nx[WIDTH-1:0];
                end
                DONE: if (bad_q) err_q <= 1'b1;
            endcase
        end
    end
    assign bus.N_INV    = n_inv;
    assign bus.R2_MOD_N = r2;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_rsa_precompute.sv
// tb_rsa_precompute: directed checks of the precompute block at WIDTH=64 and WIDTH=8.
module tb_rsa_precompute;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    rsa_precompute_if #(64) b64 ();
    rsa_precompute_if #(8)  b8 ();
    rsa_precompute #(.WIDTH(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));
    rsa_precompute #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // lat = number of edges after the accepting edge until done is first seen
    task automatic go64(input logic [63:0] n, input string tag, output int lat, output bit busy_seen);
        @(negedge clk);
        b64.N = n;
        b64.start = 1'b1;
        @(negedge clk);
        b64.start = 1'b0;
        lat = 0;
        busy_seen = b64.busy;
        while (!b64.done && lat < 400) begin
            @(negedge clk);
            lat++;
            if (b64.busy) busy_seen = 1'b1;
        end
        @(negedge clk);
        chk({tag, "_done_fall"}, 64'(b64.done), 64'd0);
    endtask

    task automatic go8(input logic [7:0] n, input string tag, output int lat);
        @(negedge clk);
        b8.N = n;
        b8.start = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        lat = 0;
        while (!b8.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
        chk({tag, "_done_fall"}, 64'(b8.done), 64'd0);
    endtask

    initial begin
        int lat;
        int n;
        bit bs;
        bit seen;
        logic [63:0] p;
        b64.start = 1'b0;
        b64.N = '0;
        b8.start = 1'b0;
        b8.N = '0;
        repeat (3) @(negedge clk);
        chk("rst_ninv", b64.N_INV, 64'd0);
        chk("rst_r2", b64.R2_MOD_N, 64'd0);
        chk("rst_busy", 64'(b64.busy), 64'd0);
        chk("rst_done", 64'(b64.done), 64'd0);
        chk("rst_err", 64'(b64.err), 64'd0);
        chk("rst8_ninv", 64'(b8.N_INV), 64'd0);
        rst_n = 1'b1;

        go64(64'd11, "n11", lat, bs);
        chk("n11_lat", 64'(lat), 64'd191);
        chk("n11_busy", 64'(bs), 64'd1);
        chk("n11_ninv", b64.N_INV, 64'hD1745D1745D1745D);
        chk("n11_r2", b64.R2_MOD_N, 64'd3);
        chk("n11_err", 64'(b64.err), 64'd0);

        go64(64'd3, "n3", lat, bs);
        chk("n3_ninv", b64.N_INV, 64'h5555555555555555);
        chk("n3_r2", b64.R2_MOD_N, 64'd1);

        go64(64'hFFFFFFFFFFFFFFFF, "nmax", lat, bs);
        chk("nmax_ninv", b64.N_INV, 64'd1);
        chk("nmax_r2", b64.R2_MOD_N, 64'd1);
        chk("nmax_lat", 64'(lat), 64'd191);

        go64(64'd10, "n10", lat, bs);
        chk("n10_lat", 64'(lat), 64'd1);
        chk("n10_busy", 64'(bs), 64'd0);
        chk("n10_err", 64'(b64.err), 64'd1);
        chk("n10_ninv", b64.N_INV, 64'd0);
        chk("n10_r2", b64.R2_MOD_N, 64'd0);

        go64(64'd1, "n1", lat, bs);
        chk("n1_lat", 64'(lat), 64'd1);
        chk("n1_busy", 64'(bs), 64'd0);
        chk("n1_err", 64'(b64.err), 64'd1);
        chk("n1_ninv", b64.N_INV, 64'd0);

        // a start and N churn while busy must not disturb the N=11 run
        @(negedge clk);
        b64.N = 64'd11;
        b64.start = 1'b1;
        @(negedge clk);
        b64.start = 1'b0;
        lat = 0;
        while (!b64.done && lat < 400) begin
            @(negedge clk);
            lat++;
            b64.start = (lat == 49);
            b64.N = (lat == 49) ? 64'd13 : {$urandom, $urandom};
        end
        b64.start = 1'b0;
        chk("ign_lat", 64'(lat), 64'd191);
        chk("ign_err", 64'(b64.err), 64'd0);
        chk("ign_ninv", b64.N_INV, 64'hD1745D1745D1745D);
        chk("ign_r2", b64.R2_MOD_N, 64'd3);
        @(negedge clk);
        chk("ign_done_fall", 64'(b64.done), 64'd0);

        go64(64'd13, "n13", lat, bs);
        chk("n13_r2", b64.R2_MOD_N, 64'd9);
        p = 64'd13 * b64.N_INV + 64'd1;
        chk("n13_ninv", p, 64'd0);

        // reset in the middle of a computation
        @(negedge clk);
        b64.N = 64'd11;
        b64.start = 1'b1;
        @(negedge clk);
        b64.start = 1'b0;
        repeat (99) @(negedge clk);
        chk("mid_busy_pre", 64'(b64.busy), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_ninv", b64.N_INV, 64'd0);
        chk("mid_r2", b64.R2_MOD_N, 64'd0);
        chk("mid_busy", 64'(b64.busy), 64'd0);
        chk("mid_err", 64'(b64.err), 64'd0);
        seen = b64.done;
        repeat (150) begin
            @(negedge clk);
            if (b64.done || b64.busy) seen = 1'b1;
        end
        chk("mid_no_done", 64'(seen), 64'd0);
        go64(64'd11, "post", lat, bs);
        chk("post_lat", 64'(lat), 64'd191);
        chk("post_ninv", b64.N_INV, 64'hD1745D1745D1745D);
        chk("post_r2", b64.R2_MOD_N, 64'd3);

        go8(8'd11, "w8", lat);
        chk("w8_lat", 64'(lat), 64'd23);
        chk("w8_ninv", 64'(b8.N_INV), 64'd93);
        chk("w8_r2", 64'(b8.R2_MOD_N), 64'd9);
        for (int i = 0; i < 200; i++) begin
            n = $urandom_range(1, 127) * 2 + 1;
            go8(8'(n), "rnd", lat);
            chk("rnd_lat", 64'(lat), 64'd23);
            chk("rnd_ninv", 64'((n * int'(b8.N_INV) + 1) % 256), 64'd0);
            chk("rnd_r2", 64'(b8.R2_MOD_N), 64'(65536 % n));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
